// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// inst_fetch_pkg: shared widths, reset PC and fetch FSM encoding for the fetch unit.
// Rev 1.0
package inst_fetch_pkg;

   localparam int          IF_ADDR_WIDTH = 32;
   localparam int          IF_INST_WIDTH = 32;
   localparam logic [31:0] IF_RESET_PC   = 32'h1C00_0000;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_buffer.sv
`default_nettype none
// if_buffer: single-entry fetch output register with valid/ready handshake and flush.
// Rev 1.0
module if_buffer
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = IF_ADDR_WIDTH,
   parameter int INST_WIDTH = IF_INST_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  load_i,
   input  logic [INST_WIDTH-1:0] load_inst_i,
   input  logic [ADDR_WIDTH-1:0] load_pc_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic                  valid_q, valid_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;

   // Load wins over a same-cycle drain so the entry is refilled back-to-back.
   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         inst_d  = load_inst_i;
         pc_d    = load_pc_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// inst_fetch: single-outstanding instruction fetch with branch/jump redirect and drop.
// Rev 1.0
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = IF_ADDR_WIDTH,
   parameter int                    INST_WIDTH = IF_INST_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IF_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [INST_WIDTH-1:0] imem_rdata_i,
   output logic                  if_valid_o,
   output logic [INST_WIDTH-1:0] if_inst_o,
   output logic [ADDR_WIDTH-1:0] if_pc_o,
   input  logic                  id_ready_i,
   input  logic                  branch_en_i,
   input  logic                  jump_en_i,
   input  logic [ADDR_WIDTH-1:0] branch_addr_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  drop_q, drop_d;
   logic [INST_WIDTH-1:0] hold_inst_q, hold_inst_d;
   logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;

   logic                  redirect;
   logic                  drained;
   logic [ADDR_WIDTH-1:0] target;
   logic                  buf_load;
   logic [INST_WIDTH-1:0] buf_inst;
   logic [ADDR_WIDTH-1:0] buf_pc;

   assign redirect = if_valid_o && (branch_en_i || jump_en_i);
   assign target   = branch_en_i ? branch_addr_i : jump_addr_i;
   assign drained  = !if_valid_o || id_ready_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_d      = drop_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      buf_load    = 1'b0;
      buf_inst    = imem_rdata_i;
      buf_pc      = pc_q;
      case (state_q)
         S_REQ: begin
            if (redirect) begin
               pc_d = target;
               // The granted address is the pre-redirect pc, so its data must be thrown away.
               if (imem_gnt_i) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else if (imem_gnt_i) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d = target;
               if (imem_rvalid_i) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_rvalid_i) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  pc_d = pc_q + ADDR_WIDTH'(4);
                  if (drained) begin
                     buf_load = 1'b1;
                     state_d  = S_REQ;
                  end else begin
                     // Output still occupied: park the response until decode takes the old one.
                     hold_inst_d = imem_rdata_i;
                     hold_pc_d   = pc_q;
                     state_d     = S_HOLD;
                  end
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = S_REQ;
            end else if (id_ready_i) begin
               buf_load = 1'b1;
               buf_inst = hold_inst_q;
               buf_pc   = hold_pc_q;
               state_d  = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         drop_q      <= 1'b0;
         hold_inst_q <= '0;
         hold_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_q      <= drop_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
      end
   end

   // Gated by rst_n so the request vanishes the moment reset asserts.
   assign imem_req_o  = rst_n && (state_q == S_REQ);
   assign imem_addr_o = pc_q;

   if_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INST_WIDTH (INST_WIDTH)
   ) u_if_buffer (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect),
      .load_i      (buf_load),
      .load_inst_i (buf_inst),
      .load_pc_i   (buf_pc),
      .ready_i     (id_ready_i),
      .valid_o     (if_valid_o),
      .inst_o      (if_inst_o),
      .pc_o        (if_pc_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// tb_inst_fetch: directed and randomized checks of inst_fetch against an instruction-stream model.
// Rev 1.0
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        branch_en;
   logic        jump_en;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;

   int vectors     = 0;
   int miscompares = 0;

   // memory / stream model state
   bit          out_q;
   logic [31:0] out_addr;
   int          lat;
   logic [31:0] exp_pc;
   int          wait_cnt;
   bit          p_req_wait;
   logic [31:0] p_addr;
   bit          p_stall;
   logic [31:0] p_pc;
   logic [31:0] p_inst;

   // knobs
   bit rand_mode = 1'b0;
   int gnt_delay = 0;
   int gnt_pct   = 100;
   int lat_min   = 0;
   int lat_max   = 0;
   int rdy_pct   = 100;
   int redir_pct = 0;
   int spur_pct  = 0;

   inst_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .if_valid_o    (if_valid),
      .if_inst_o     (if_inst),
      .if_pc_o       (if_pc),
      .id_ready_i    (id_ready),
      .branch_en_i   (branch_en),
      .jump_en_i     (jump_en),
      .branch_addr_i (branch_addr),
      .jump_addr_i   (jump_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h1C00_0000) return 32'h0280_0421;
      return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   function automatic logic [31:0] rtarget();
      if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      return 32'h1C00_0000 + 32'($urandom_range(0, 255) * 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      out_q      = 1'b0;
      lat        = 0;
      exp_pc     = RESET_PC;
      wait_cnt   = 0;
      p_req_wait = 1'b0;
      p_stall    = 1'b0;
   endtask

   // Drive one cycle of inputs, check against the model, advance to edge+1.
   task automatic cycle();
      logic        redir;
      logic        hs;
      logic [31:0] tgt;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (out_q && lat == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memfn(out_addr);
      end else if (!out_q && int'($urandom_range(0, 99)) < spur_pct) begin
         imem_rvalid = 1'b1;
      end
      imem_gnt = imem_req && (wait_cnt >= gnt_delay) && (int'($urandom_range(0, 99)) < gnt_pct);
      if (rand_mode) begin
         id_ready    = int'($urandom_range(0, 99)) < rdy_pct;
         branch_en   = int'($urandom_range(0, 99)) < redir_pct;
         jump_en     = int'($urandom_range(0, 99)) < redir_pct;
         branch_addr = rtarget();
         jump_addr   = rtarget();
      end
      if (if_valid) begin
         chk("stream_pc", if_pc, exp_pc);
         chk("stream_inst", if_inst, memfn(exp_pc));
      end
      if (p_stall) begin
         chk("stall_valid", {31'd0, if_valid}, 32'd1);
         chk("stall_pc", if_pc, p_pc);
         chk("stall_inst", if_inst, p_inst);
      end
      if (p_req_wait) begin
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_held", imem_addr, p_addr);
      end
      if (out_q) chk("single_outstanding", {31'd0, imem_req}, 32'd0);
      redir = if_valid && (branch_en || jump_en);
      tgt   = branch_en ? branch_addr : jump_addr;
      hs    = if_valid && id_ready;
      if (out_q && imem_rvalid) out_q = 1'b0;
      else if (out_q) lat--;
      if (imem_req && imem_gnt) begin
         out_q    = 1'b1;
         out_addr = imem_addr;
         lat      = int'($urandom_range(lat_min, lat_max));
      end
      if (redir) exp_pc = tgt;
      else if (hs) exp_pc = exp_pc + 32'd4;
      p_req_wait = imem_req && !imem_gnt && !redir;
      p_addr     = imem_addr;
      p_stall    = if_valid && !id_ready && !redir;
      p_pc       = if_pc;
      p_inst     = if_inst;
      wait_cnt   = (imem_req && !imem_gnt) ? wait_cnt + 1 : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!if_valid && n < budget) begin
         cycle();
         n++;
      end
      chk("wait_valid", {31'd0, if_valid}, 32'd1);
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!imem_req && n < budget) begin
         cycle();
         n++;
      end
      chk("wait_req", {31'd0, imem_req}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
      chk({tag, "_if_inst"}, if_inst, 32'd0);
      chk({tag, "_if_pc"}, if_pc, 32'd0);
      chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      id_ready    = 1'b0;
      branch_en   = 1'b0;
      jump_en     = 1'b0;
      branch_addr = '0;
      jump_addr   = '0;
      #1;
      chk("rst_req_immediate", {31'd0, imem_req}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      model_reset();
      rst_n = 1'b1;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, RESET_PC);
   endtask

   initial begin
      do_reset();

      // Basic fetch: grant and response one cycle apart each.
      gnt_delay = 1;
      id_ready  = 1'b1;
      cycle();
      chk("addr_stable_no_gnt", imem_addr, RESET_PC);
      cycle();
      chk("wait_no_req", {31'd0, imem_req}, 32'd0);
      cycle();
      chk("first_valid", {31'd0, if_valid}, 32'd1);
      chk("first_if_pc", if_pc, 32'h1C00_0000);
      chk("first_if_inst", if_inst, 32'h0280_0421);
      chk("next_addr", imem_addr, 32'h1C00_0004);

      // Decode stalls while a second response arrives -> hold state.
      cycle();
      wait_valid(10);
      chk("second_if_pc", if_pc, 32'h1C00_0004);
      id_ready = 1'b0;
      repeat (3) cycle();
      for (int i = 0; i < 3; i++) begin
         chk("hold_no_req", {31'd0, imem_req}, 32'd0);
         chk("hold_if_pc", if_pc, 32'h1C00_0004);
         cycle();
      end
      id_ready = 1'b1;
      cycle();
      chk("after_hold_pc", if_pc, 32'h1C00_0008);
      chk("after_hold_req", {31'd0, imem_req}, 32'd1);
      chk("after_hold_addr", imem_addr, 32'h1C00_000C);

      // Branch while a request is in flight: response dropped.
      id_ready  = 1'b0;
      gnt_delay = 0;
      lat_min   = 2;
      lat_max   = 2;
      cycle();
      chk("inflight_no_req", {31'd0, imem_req}, 32'd0);
      branch_en   = 1'b1;
      branch_addr = 32'h1C00_0100;
      cycle();
      branch_en = 1'b0;
      id_ready  = 1'b1;
      chk("redirect_flush", {31'd0, if_valid}, 32'd0);
      wait_req(10);
      chk("branch_addr", imem_addr, 32'h1C00_0100);
      chk("branch_no_valid", {31'd0, if_valid}, 32'd0);
      lat_min = 0;
      lat_max = 0;
      wait_valid(10);
      chk("branch_if_pc", if_pc, 32'h1C00_0100);

      // Branch has priority over jump; redirect coincides with a grant.
      branch_en   = 1'b1;
      jump_en     = 1'b1;
      branch_addr = 32'h0000_0100;
      jump_addr   = 32'h0000_0200;
      cycle();
      branch_en = 1'b0;
      jump_en   = 1'b0;
      wait_req(10);
      chk("prio_addr", imem_addr, 32'h0000_0100);
      wait_valid(10);
      chk("prio_if_pc", if_pc, 32'h0000_0100);

      // PC wrap at the top of the address space.
      jump_en   = 1'b1;
      jump_addr = 32'hFFFF_FFFC;
      cycle();
      jump_en = 1'b0;
      wait_req(10);
      chk("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
      wait_valid(10);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_req", {31'd0, imem_req}, 32'd1);
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // Randomized traffic against the stream model.
      rand_mode = 1'b1;
      gnt_pct   = 60;
      lat_min   = 0;
      lat_max   = 3;
      rdy_pct   = 70;
      redir_pct = 10;
      spur_pct  = 20;
      repeat (3000) cycle();
      rand_mode = 1'b0;
      gnt_pct   = 100;
      spur_pct  = 0;
      branch_en = 1'b0;
      jump_en   = 1'b0;
      id_ready  = 1'b1;

      // Reset while requesting.
      wait_req(20);
      rst_n = 1'b0;
      #1;
      chk("midreq_reset_req", {31'd0, imem_req}, 32'd0);
      do_reset();

      // Reset in the wait state with a response arriving during reset.
      id_ready = 1'b1;
      lat_min  = 1;
      lat_max  = 1;
      begin
         int n = 0;
         while (!out_q && n < 20) begin
            cycle();
            n++;
         end
      end
      chk("s_wait_reached", {31'd0, imem_req}, 32'd0);
      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      #1;
      check_reset_outputs("rstwait_a");
      @(posedge clk);
      #1;
      check_reset_outputs("rstwait_b");
      imem_rvalid = 1'b0;
      model_reset();
      lat_min = 0;
      lat_max = 0;
      rst_n   = 1'b1;
      #1;
      chk("rstwait_req", {31'd0, imem_req}, 32'd1);
      chk("rstwait_addr", imem_addr, RESET_PC);
      wait_valid(10);
      chk("rstwait_if_pc", if_pc, RESET_PC);
      chk("rstwait_if_inst", if_inst, 32'h0280_0421);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
